// File: rtl/wb_stage_pkg.sv
// Shared constants for the semiMIPS write-back stage: write-back select codes,
// retire FSM state encoding and the hard-wired zero register number.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_DM  = 2'b01,
    MTR_PC  = 2'b10,
    MTR_NEG = 2'b11
  } mtr_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } wb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : wb_stage_pkg

// File: rtl/wb_stage_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high clear;
// holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  output logic [CWIDTH-1:0] count_o
);

  logic [CWIDTH-1:0] count_q;
  logic [CWIDTH-1:0] count_d;

  // NOTE: default assigned first so no path through this block can infer a latch.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {CWIDTH{1'b1}})) begin
      count_d = count_q + CWIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/wb_stage.sv
// Write-back stage of the semiMIPS pipeline: write-back mux, register-file write
// port, one-entry ID bypass buffer, RUN/HALT retire FSM and saturating counters.
// Optional instruction trace outputs are enabled with `define WB_TRACE_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        memtoregin,
  input  logic              regwrin,
  input  logic              finin,
  input  logic [4:0]        regdstmuxin,
  input  logic [DWIDTH-1:0] aluoutin,
  input  logic [DWIDTH-1:0] dmdatain,
  input  logic [AWIDTH-1:0] pcnextin,
  input  logic              negativein,
  input  logic [31:0]       insin,
  output logic              rfwe,
  output logic [4:0]        rfwaddr,
  output logic [DWIDTH-1:0] rfwdata,
  output logic              fwdvalid,
  output logic [4:0]        fwdaddr,
  output logic [DWIDTH-1:0] fwddata,
  output logic              halted,
  output logic [CWIDTH-1:0] retired,
  output logic [CWIDTH-1:0] cycles
`ifdef WB_TRACE_EN
  ,
  output logic              trvalid,
  output logic [AWIDTH-1:0] trpc,
  output logic [31:0]       trins
`endif
);

  wb_state_e         state_q, state_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [4:0]        fwd_addr_q, fwd_addr_d;
  logic [DWIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [DWIDTH-1:0] pc_ext;
  logic [DWIDTH-1:0] wb_data;
  logic              in_run;
  logic              retire_en;
  logic              wr_en;

  // Link value is zero-extended or truncated to the data width.
  if (DWIDTH > AWIDTH) begin : g_pc_zext
    assign pc_ext = {{(DWIDTH-AWIDTH){1'b0}}, pcnextin};
  end else begin : g_pc_trunc
    assign pc_ext = pcnextin[DWIDTH-1:0];
  end

  always_comb begin
    wb_data = aluoutin;
    case (mtr_e'(memtoregin))
      MTR_ALU: wb_data = aluoutin;
      MTR_DM:  wb_data = dmdatain;
      MTR_PC:  wb_data = pc_ext;
      MTR_NEG: wb_data = {{(DWIDTH-1){1'b0}}, negativein};
      default: wb_data = aluoutin;
    endcase
  end

  assign in_run    = (state_q == RUN);
  assign retire_en = in_run && (insin != 32'd0);
  assign wr_en     = regwrin && (regdstmuxin != REG_ZERO) && !finin && in_run;

  assign rfwe    = wr_en;
  assign rfwaddr = regdstmuxin;
  assign rfwdata = wb_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (finin) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    fwd_valid_d = wr_en;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    if (wr_en) begin
      fwd_addr_d = regdstmuxin;
      fwd_data_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= REG_ZERO;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign fwdvalid = fwd_valid_q;
  assign fwdaddr  = fwd_addr_q;
  assign fwddata  = fwd_data_q;
  assign halted   = (state_q == HALT);

  sat_counter #(.CWIDTH(CWIDTH)) u_retired (
    .clk     (clk),
    .rst     (rst),
    .en_i    (retire_en),
    .count_o (retired)
  );

  sat_counter #(.CWIDTH(CWIDTH)) u_cycles (
    .clk     (clk),
    .rst     (rst),
    .en_i    (in_run),
    .count_o (cycles)
  );

`ifdef WB_TRACE_EN
  logic              tr_valid_q, tr_valid_d;
  logic [AWIDTH-1:0] tr_pc_q, tr_pc_d;
  logic [31:0]       tr_ins_q, tr_ins_d;

  always_comb begin
    tr_valid_d = retire_en;
    tr_pc_d    = tr_pc_q;
    tr_ins_d   = tr_ins_q;
    if (retire_en) begin
      tr_pc_d  = pcnextin - AWIDTH'(4);
      tr_ins_d = insin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tr_valid_q <= 1'b0;
      tr_pc_q    <= '0;
      tr_ins_q   <= '0;
    end else begin
      tr_valid_q <= tr_valid_d;
      tr_pc_q    <= tr_pc_d;
      tr_ins_q   <= tr_ins_d;
    end
  end

  assign trvalid = tr_valid_q;
  assign trpc    = tr_pc_q;
  assign trins   = tr_ins_q;
`endif

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: default-width instance plus a
// CWIDTH=4 instance sharing the same stimulus for counter saturation.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  memtoregin;
  logic        regwrin;
  logic        finin;
  logic [4:0]  regdstmuxin;
  logic [31:0] aluoutin;
  logic [31:0] dmdatain;
  logic [31:0] pcnextin;
  logic        negativein;
  logic [31:0] insin;

  logic        rfwe, fwdvalid, halted;
  logic [4:0]  rfwaddr, fwdaddr;
  logic [31:0] rfwdata, fwddata, retired, cycles;

  logic        s_rfwe, s_fwdvalid, s_halted;
  logic [4:0]  s_rfwaddr, s_fwdaddr;
  logic [31:0] s_rfwdata, s_fwddata;
  logic [3:0]  s_retired, s_cycles;

`ifdef WB_TRACE_EN
  logic        trvalid, s_trvalid;
  logic [31:0] trpc, trins, s_trpc, s_trins;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  wb_stage dut (
    .clk(clk), .rst(rst), .memtoregin(memtoregin), .regwrin(regwrin), .finin(finin),
    .regdstmuxin(regdstmuxin), .aluoutin(aluoutin), .dmdatain(dmdatain),
    .pcnextin(pcnextin), .negativein(negativein), .insin(insin),
    .rfwe(rfwe), .rfwaddr(rfwaddr), .rfwdata(rfwdata), .fwdvalid(fwdvalid),
    .fwdaddr(fwdaddr), .fwddata(fwddata), .halted(halted), .retired(retired),
    .cycles(cycles)
`ifdef WB_TRACE_EN
    , .trvalid(trvalid), .trpc(trpc), .trins(trins)
`endif
  );

  wb_stage #(.CWIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .memtoregin(memtoregin), .regwrin(regwrin), .finin(finin),
    .regdstmuxin(regdstmuxin), .aluoutin(aluoutin), .dmdatain(dmdatain),
    .pcnextin(pcnextin), .negativein(negativein), .insin(insin),
    .rfwe(s_rfwe), .rfwaddr(s_rfwaddr), .rfwdata(s_rfwdata), .fwdvalid(s_fwdvalid),
    .fwdaddr(s_fwdaddr), .fwddata(s_fwddata), .halted(s_halted), .retired(s_retired),
    .cycles(s_cycles)
`ifdef WB_TRACE_EN
    , .trvalid(s_trvalid), .trpc(s_trpc), .trins(s_trins)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] mtr, input logic we, input logic fin,
                       input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] ins);
    memtoregin  = mtr;
    regwrin     = we;
    finin       = fin;
    regdstmuxin = dst;
    aluoutin    = alu;
    insin       = ins;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    dmdatain   = 32'd0;
    pcnextin   = 32'd0;
    negativein = 1'b0;

    #2;
    check("reset_halted",   {63'd0, halted},   64'd0);
    check("reset_fwdvalid", {63'd0, fwdvalid}, 64'd0);
    check("reset_fwdaddr",  {59'd0, fwdaddr},  64'd0);
    check("reset_fwddata",  {32'd0, fwddata},  64'd0);
    check("reset_retired",  {32'd0, retired},  64'd0);
    check("reset_cycles",   {32'd0, cycles},   64'd0);

    // Release reset between edges, then a plain ALU write to r5.
    #10;
    rst = 1'b0;
    drive(2'b00, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h00A62820);
    #1;
    check("alu_rfwe",    {63'd0, rfwe},    64'd1);
    check("alu_rfwaddr", {59'd0, rfwaddr}, 64'd5);
    check("alu_rfwdata", {32'd0, rfwdata}, 64'h1234);
    step();
    check("alu_fwdvalid", {63'd0, fwdvalid}, 64'd1);
    check("alu_fwdaddr",  {59'd0, fwdaddr},  64'd5);
    check("alu_fwddata",  {32'd0, fwddata},  64'h1234);
    check("alu_retired",  {32'd0, retired},  64'd1);
    check("alu_cycles",   {32'd0, cycles},   64'd1);

    // Write-back select sweep within one cycle.
    dmdatain   = 32'hDEADBEEF;
    pcnextin   = 32'h40;
    negativein = 1'b1;
    memtoregin = 2'b01;
    #1 check("sel_dm",  {32'd0, rfwdata}, 64'hDEADBEEF);
    memtoregin = 2'b10;
    #1 check("sel_pc",  {32'd0, rfwdata}, 64'h40);
    memtoregin = 2'b11;
    #1 check("sel_neg", {32'd0, rfwdata}, 64'h1);
    negativein = 1'b0;
    #1 check("sel_neg0", {32'd0, rfwdata}, 64'h0);
    negativein = 1'b1;
    step();
    check("sel_fwddata", {32'd0, fwddata}, 64'h1);
    check("sel_retired", {32'd0, retired}, 64'd2);

    // Destination r0: no write, buffer invalidates but keeps addr/data.
    drive(2'b00, 1'b1, 1'b0, 5'd0, 32'h5555, 32'h00001020);
    #1 check("r0_rfwe", {63'd0, rfwe}, 64'd0);
    step();
    check("r0_fwdvalid", {63'd0, fwdvalid}, 64'd0);
    check("r0_fwdaddr",  {59'd0, fwdaddr},  64'd5);
    check("r0_fwddata",  {32'd0, fwddata},  64'h1);
    check("r0_retired",  {32'd0, retired},  64'd3);

    // Fresh reset, then bubble/real/bubble/real/real and the finish instruction.
    rst = 1'b1;
    #1 check("rst2_retired", {32'd0, retired}, 64'd0);
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    drive(2'b00, 1'b1, 1'b0, 5'd1, 32'h11, 32'h00000001);
    step();
    drive(2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    drive(2'b00, 1'b1, 1'b0, 5'd2, 32'h22, 32'h00000002);
    step();
    drive(2'b00, 1'b1, 1'b0, 5'd3, 32'h33, 32'h00000003);
    step();
    check("prefin_fwdvalid", {63'd0, fwdvalid}, 64'd1);
    drive(2'b00, 1'b1, 1'b1, 5'd7, 32'h77, 32'hFC000000);
    #1 check("fin_rfwe", {63'd0, rfwe}, 64'd0);
    step();
    check("fin_halted",   {63'd0, halted},   64'd1);
    check("fin_retired",  {32'd0, retired},  64'd4);
    check("fin_cycles",   {32'd0, cycles},   64'd6);
    check("fin_fwdvalid", {63'd0, fwdvalid}, 64'd0);
    check("fin_fwdaddr",  {59'd0, fwdaddr},  64'd3);
    check("fin_fwddata",  {32'd0, fwddata},  64'h33);

    // HALT ignores further traffic.
    drive(2'b00, 1'b1, 1'b0, 5'd9, 32'h99, 32'h00000009);
    #1 check("halt_rfwe", {63'd0, rfwe}, 64'd0);
    step();
    step();
    check("halt_halted",   {63'd0, halted},   64'd1);
    check("halt_retired",  {32'd0, retired},  64'd4);
    check("halt_cycles",   {32'd0, cycles},   64'd6);
    check("halt_fwdvalid", {63'd0, fwdvalid}, 64'd0);

    // Asynchronous reset mid-cycle, well before the next edge.
    #3;
    rst = 1'b1;
    #1;
    check("arst_halted",   {63'd0, halted},   64'd0);
    check("arst_fwdaddr",  {59'd0, fwdaddr},  64'd0);
    check("arst_fwddata",  {32'd0, fwddata},  64'd0);
    check("arst_retired",  {32'd0, retired},  64'd0);
    check("arst_cycles",   {32'd0, cycles},   64'd0);
    check("arst_fwdvalid", {63'd0, fwdvalid}, 64'd0);
    #1;
    rst = 1'b0;

    // Saturation on the 4-bit counter instance.
    drive(2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h00000020);
    for (int i = 0; i < 15; i++) step();
    check("sat15_retired", {60'd0, s_retired}, 64'hF);
    for (int i = 0; i < 5; i++) step();
    check("sat20_retired", {60'd0, s_retired}, 64'hF);
    check("sat20_cycles",  {60'd0, s_cycles},  64'hF);
    check("wide20_retired", {32'd0, retired},  64'd20);
    check("wide20_cycles",  {32'd0, cycles},   64'd20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_wb_stage
